// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes and bounce direction.
package led_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ROR    = 2'd0;
  localparam mode_t MODE_ROL    = 2'd1;
  localparam mode_t MODE_BOUNCE = 2'd2;
  localparam mode_t MODE_BAR    = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage : led_pkg

// File: rtl/led_tick_div.sv
// Programmable prescaler: emits a one-cycle combinational tick every div_q+1 unpaused clocks.
module led_tick_div #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned DIV_RST = 2499999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] div,
  input  logic             div_we,
  input  logic             pause,
  output logic             tick_c
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] div_nxt;

  // ">=" lets a lowered divider take effect on the very next cycle
  always_comb begin
    tick_c  = 1'b0;
    cnt_nxt = cnt;
    div_nxt = div_q;
    if (div_we) begin
      div_nxt = div;
    end
    if (!pause) begin
      tick_c  = (cnt >= div_q);
      cnt_nxt = tick_c ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      div_q <= CNT_W'(DIV_RST);
    end else begin
      cnt   <= cnt_nxt;
      div_q <= div_nxt;
    end
  end

endmodule : led_tick_div

// File: rtl/led_pattern_gen.sv
// Multi-mode active-low LED pattern generator (ROR, ROL, BOUNCE, BAR) driven by a prescaler tick.
// Optional brightness PWM on lit LEDs when LED_PWM_EN is defined.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned LED_NUM = 4,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned DIV_RST = 2499999
`ifdef LED_PWM_EN
  ,
  parameter int unsigned PWM_W   = 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   div,
  input  logic               div_we,
  input  logic               pause,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]   bright,
`endif
  output logic               step,
  output logic [LED_NUM-1:0] led_sig
);

  localparam int unsigned POS_W = $clog2(LED_NUM);
  localparam int unsigned BAR_W = $clog2(LED_NUM + 1);

  logic tick_c;

  led_tick_div #(
    .CNT_W   (CNT_W),
    .DIV_RST (DIV_RST)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .div    (div),
    .div_we (div_we),
    .pause  (pause),
    .tick_c (tick_c)
  );

  mode_t              mode_q;
  logic [LED_NUM-1:0] pat;
  logic [POS_W-1:0]   pos;
  logic               dir;
  logic [BAR_W-1:0]   bar;

  mode_t              mode_nxt;
  logic [LED_NUM-1:0] pat_nxt;
  logic [POS_W-1:0]   pos_nxt;
  logic               dir_nxt;
  logic [BAR_W-1:0]   bar_nxt;
  logic [LED_NUM-1:0] led_nxt;
  logic               pwm_on_c;

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  assign pwm_on_c = (pwm_cnt < bright);
`else
  assign pwm_on_c = 1'b1;
`endif

  // Next pattern state: reload on a mode change, otherwise advance one step per tick
  always_comb begin
    mode_nxt = mode_q;
    pat_nxt  = pat;
    pos_nxt  = pos;
    dir_nxt  = dir;
    bar_nxt  = bar;
    if (tick_c) begin
      mode_nxt = mode;
      if (mode != mode_q) begin
        pos_nxt = '0;
        dir_nxt = DIR_UP;
        bar_nxt = '0;
        pat_nxt = (mode == MODE_BAR) ? '0 : LED_NUM'(1);
      end else begin
        case (mode_q)
          MODE_ROR: pat_nxt = {pat[0], pat[LED_NUM-1:1]};
          MODE_ROL: pat_nxt = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
          MODE_BOUNCE: begin
            if (dir == DIR_UP) begin
              if (pos == POS_W'(LED_NUM - 1)) begin
                dir_nxt = DIR_DN;
                pos_nxt = POS_W'(LED_NUM - 2);
              end else begin
                pos_nxt = pos + POS_W'(1);
              end
            end else begin
              if (pos == '0) begin
                dir_nxt = DIR_UP;
                pos_nxt = POS_W'(1);
              end else begin
                pos_nxt = pos - POS_W'(1);
              end
            end
            pat_nxt = LED_NUM'(1) << pos_nxt;
          end
          default: begin
            bar_nxt = (bar == BAR_W'(LED_NUM)) ? '0 : bar + BAR_W'(1);
            for (int i = 0; i < int'(LED_NUM); i++) begin
              pat_nxt[i] = (BAR_W'(i) < bar_nxt);
            end
          end
        endcase
      end
    end
    led_nxt = ~(pat_nxt & {LED_NUM{pwm_on_c}});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q  <= MODE_ROR;
      pat     <= LED_NUM'(1);
      pos     <= '0;
      dir     <= DIR_UP;
      bar     <= '0;
      step    <= 1'b0;
      led_sig <= ~LED_NUM'(1);
    end else begin
      mode_q  <= mode_nxt;
      pat     <= pat_nxt;
      pos     <= pos_nxt;
      dir     <= dir_nxt;
      bar     <= bar_nxt;
      step    <= tick_c;
      led_sig <= led_nxt;
    end
  end

`ifdef LED_PWM_EN
  // Free-running brightness counter; keeps running through pause
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end
`endif

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
// Randomized self-checking bench for led_pattern_gen against a step-count pattern model.
module tb_led_pattern_gen;

  localparam int N  = 4;
  localparam int CW = 24;
  localparam int DIV_DEFAULT = 2499999;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [CW-1:0] div;
  logic          div_we;
  logic          pause;
  logic          step;
  logic [N-1:0]  led_sig;
`ifdef LED_PWM_EN
  logic [3:0]    bright;
`endif

  int total = 0;
  int bad   = 0;

  // model state
  int           m_cnt;
  int           m_divq;
  int           m_mode;
  int           m_k;
  int           m_pwm;
  logic         exp_step;
  logic [N-1:0] exp_led;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .LED_NUM (N),
    .CNT_W   (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .div     (div),
    .div_we  (div_we),
    .pause   (pause),
`ifdef LED_PWM_EN
    .bright  (bright),
`endif
    .step    (step),
    .led_sig (led_sig)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Active-high pattern after k advances since the pattern (re)started in mode md
  function automatic logic [N-1:0] pat_of(input int md, input int k);
    logic [N-1:0] r;
    int p;
    r = '0;
    case (md)
      0: r[(N - (k % N)) % N] = 1'b1;
      1: r[k % N] = 1'b1;
      2: begin
        p = k % (2 * N - 2);
        r[(p < N) ? p : (2 * N - 2 - p)] = 1'b1;
      end
      default: begin
        p = k % (N + 1);
        for (int i = 0; i < N; i++) r[i] = (i < p);
      end
    endcase
    return r;
  endfunction

  // One clock: update the model on the rising edge, compare on the falling edge
  task automatic cycle();
    logic tick;
    logic on;
    @(posedge clk);
    if (!rst) begin
      m_cnt    = 0;
      m_divq   = DIV_DEFAULT;
      m_mode   = 0;
      m_k      = 0;
      m_pwm    = 0;
      exp_step = 1'b0;
      exp_led  = ~pat_of(0, 0);
    end else begin
      tick = !pause && (m_cnt >= m_divq);
      if (!pause) m_cnt = tick ? 0 : m_cnt + 1;
      if (div_we) m_divq = int'(div);
      if (tick) begin
        if (int'(mode) != m_mode) begin
          m_mode = int'(mode);
          m_k    = 0;
        end else begin
          m_k++;
        end
      end
      exp_step = tick;
`ifdef LED_PWM_EN
      on    = (m_pwm < int'(bright));
      m_pwm = (m_pwm + 1) % 16;
`else
      on    = 1'b1;
`endif
      exp_led = ~(pat_of(m_mode, m_k) & {N{on}});
    end
    @(negedge clk);
    chk("led_sig", 32'(led_sig), 32'(exp_led));
    chk("step", 32'(step), 32'(exp_step));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst    = 1'b0;
    mode   = 2'd0;
    div    = '0;
    div_we = 1'b0;
    pause  = 1'b0;
`ifdef LED_PWM_EN
    bright = 4'd15;
`endif
    run(3);
    chk("reset_led", 32'(led_sig), 32'h0000_000e);
    chk("reset_step", 32'(step), 32'h0);

    // ROR at div=3
    rst = 1'b1; div = CW'(3); div_we = 1'b1;
    cycle();
    div_we = 1'b0;
    run(20);
    // ROL, BOUNCE at div=0, then BAR with a pause
    mode = 2'd1; run(20);
    mode = 2'd2; div = '0; div_we = 1'b1; cycle(); div_we = 1'b0; run(16);
    mode = 2'd3; run(7);
    pause = 1'b1; run(10);
    pause = 1'b0; run(8);
    // lowering the divider mid-count ticks on the following cycle
    div = CW'(1000); div_we = 1'b1; cycle(); div_we = 1'b0; run(500);
    div = CW'(10); div_we = 1'b1; cycle(); div_we = 1'b0;
    cycle();
    chk("div_lower_tick", 32'(step), 32'h1);
    run(25);
    // reset mid-BAR and over a pending divider write
    rst = 1'b0; div = CW'(2); div_we = 1'b1; pause = 1'b1; cycle();
    chk("rst_mid_led", 32'(led_sig), 32'h0000_000e);
    rst = 1'b1; div_we = 1'b1; pause = 1'b0; cycle(); div_we = 1'b0;
`ifdef LED_PWM_EN
    bright = 4'd4; mode = 2'd0; div = CW'(200); div_we = 1'b1; cycle(); div_we = 1'b0;
    run(48);
    bright = 4'd0; run(20);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 299) != 0);
      div_we = ($urandom_range(0, 19) == 0);
      div    = CW'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
`ifdef LED_PWM_EN
      if ($urandom_range(0, 49) == 0) bright = 4'($urandom_range(0, 15));
`endif
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_led_pattern_gen
